// File: rtl/rx_packet_buffer_pkg.sv
// Shared defaults, write-FSM state encoding and depth-width helper for the RX packet buffer.
package comms_rx_pkt_pkg;

  localparam int NUM_BUF_DEF = 4;
  localparam int BUF_AW_DEF  = 8;
  localparam int DEPTH_W_DEF = BUF_AW_DEF + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  // Depth must hold a full buffer (2^aw bytes), hence one extra bit.
  function automatic int depth_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/rx_pkt_ram.sv
// Simple dual-port byte RAM, addressed {buffer, offset}, with a registered read port.
module rx_pkt_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array contents are left as-is.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rx_packet_buffer.sv
// Multi-buffer RX packet store between the Manchester decoder and the processor.
// Define RX_PKT_CRC_DROP_EN to discard CRC-errored packets instead of committing them.
module rx_packet_buffer
  import comms_rx_pkt_pkg::*;
#(
  parameter  int NUM_BUF = NUM_BUF_DEF,
  parameter  int BUF_AW  = BUF_AW_DEF,
  localparam int PW      = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1,
  localparam int DW      = depth_w(BUF_AW)
) (
  input  logic          clk16x,
  input  logic          reset,
  input  logic          wr_byte_vld,
  input  logic [7:0]    wr_byte,
  input  logic          wr_sop,
  input  logic          wr_eop,
  input  logic          wr_crc_err,
  input  logic          rd_en,
  input  logic          rd_done,
  output logic [7:0]    rd_data,
  output logic          rx_packet_avail,
  output logic [DW-1:0] rx_packet_depth,
  output logic          rx_crc_error,
  output logic          rx_fifo_overflow,
  output logic          rx_fifo_underrun,
  output logic [PW-1:0] readfifo_write_ptr,
  output logic [PW-1:0] readfifo_read_ptr
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(NUM_BUF);

  wr_state_e          state_q;
  logic [PW:0]        count_q;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]      wr_off_q, rd_idx_q;
  logic [DW-1:0]      len_q [NUM_BUF];
  logic               ovf_q, udr_q;

  logic               full, avail, rd_ok, release_c, commit_c, fill_eop;
  logic               idle_sop, fill_byte, ram_we;
  logic [PW+BUF_AW-1:0] ram_waddr, ram_raddr;

  assign full      = (count_q == FULL_CNT);
  assign avail     = (count_q != '0);
  assign rd_ok     = rd_en && avail && (rd_idx_q != len_q[rd_ptr_q]);
  assign release_c = rd_done && avail;
  assign fill_eop  = (state_q == ST_FILL) && wr_eop;
  assign idle_sop  = (state_q == ST_IDLE) && wr_byte_vld && wr_sop;
  assign fill_byte = (state_q == ST_FILL) && wr_byte_vld && !wr_eop;

  // A sop always lands at offset 0, whether starting or restarting a packet.
  assign ram_we    = (idle_sop && !full) || (fill_byte && (wr_sop || !wr_off_q[BUF_AW]));
  assign ram_waddr = {wr_ptr_q, wr_sop ? {BUF_AW{1'b0}} : wr_off_q[BUF_AW-1:0]};
  assign ram_raddr = {rd_ptr_q, rd_idx_q[BUF_AW-1:0]};

`ifdef RX_PKT_CRC_DROP_EN
  assign commit_c     = fill_eop && !wr_crc_err;
  assign rx_crc_error = 1'b0;
`else
  logic crc_q [NUM_BUF];

  assign commit_c     = fill_eop;
  assign rx_crc_error = avail && crc_q[rd_ptr_q];

  always_ff @(posedge clk16x) begin
    if (commit_c) crc_q[wr_ptr_q] <= wr_crc_err;
  end
`endif

  always_ff @(posedge clk16x) begin
    if (commit_c) len_q[wr_ptr_q] <= wr_off_q;
  end

  always_ff @(posedge clk16x) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_off_q <= '0;
      rd_idx_q <= '0;
      ovf_q    <= 1'b0;
      udr_q    <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      udr_q <= rd_en && !rd_ok;
      case (state_q)
        ST_IDLE: if (idle_sop) begin
          if (full) begin
            ovf_q   <= 1'b1;
            state_q <= ST_DROP;
          end else begin
            wr_off_q <= DW'(1);
            state_q  <= ST_FILL;
          end
        end
        ST_FILL: if (wr_eop) begin
          state_q <= ST_IDLE;
          if (commit_c) wr_ptr_q <= wr_ptr_q + 1'b1;
        end else if (wr_byte_vld) begin
          if (wr_sop) wr_off_q <= DW'(1);
          else if (wr_off_q[BUF_AW]) begin
            ovf_q   <= 1'b1;
            state_q <= ST_DROP;
          end else wr_off_q <= wr_off_q + 1'b1;
        end
        ST_DROP: if (wr_eop) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      if (commit_c && !release_c)      count_q <= count_q + 1'b1;
      else if (!commit_c && release_c) count_q <= count_q - 1'b1;

      if (release_c) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_idx_q <= '0;
      end else if (rd_ok) begin
        rd_idx_q <= rd_idx_q + 1'b1;
      end
    end
  end

  rx_pkt_ram #(.AW(PW + BUF_AW)) u_ram (
    .clk   (clk16x),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (wr_byte),
    .re    (rd_ok),
    .raddr (ram_raddr),
    .rdata (rd_data)
  );

  assign rx_packet_avail    = avail;
  assign rx_packet_depth    = avail ? len_q[rd_ptr_q] : '0;
  assign rx_fifo_overflow   = ovf_q;
  assign rx_fifo_underrun   = udr_q;
  assign readfifo_write_ptr = wr_ptr_q;
  assign readfifo_read_ptr  = rd_ptr_q;

endmodule
